// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: fetch PC owner issuing 1-latency imem reads into a DEPTH-entry {pc,instr} FIFO for decode (ports: clk/rst, imem_req/addr/rdata, redirect/redirect_pc, halt, instr_valid/instr/instr_pc/instr_ready, occupancy)
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     halt,
  output logic                     instr_valid,
  output logic [31:0]              instr,
  output logic [31:0]              instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
  logic          inflight_q, inflight_d, kill_q, kill_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fpc_q [DEPTH];
  logic [31:0]   fpc_d [DEPTH];
  logic [31:0]   finstr_q [DEPTH];
  logic [31:0]   finstr_d [DEPTH];
  logic          push, pop;
  assign imem_req    = !rst && !halt && !redirect && ((count_q + CW'(inflight_q)) < CW'(DEPTH));
  assign imem_addr   = pc_q;
  assign instr_valid = count_q != '0;
  assign instr       = finstr_q[rd_q];
  assign instr_pc    = fpc_q[rd_q];
  assign occupancy   = count_q;
  always_comb begin
    push       = inflight_q && !kill_q && !redirect;
    pop        = instr_valid && instr_ready && !redirect;
    fpc_d      = fpc_q;
    finstr_d   = finstr_q;
    if (push) begin
      fpc_d[wr_q]    = rsp_pc_q;
      finstr_d[wr_q] = imem_rdata;
    end
    wr_d       = redirect ? '0 : wr_q + AW'(push);
    rd_d       = redirect ? '0 : rd_q + AW'(pop);
    count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
    pc_d       = redirect ? (redirect_pc & ~32'h3) : imem_req ? pc_q + 32'd4 : pc_q;
    rsp_pc_d   = imem_req ? pc_q : rsp_pc_q;
    inflight_d = imem_req;
    kill_d     = redirect;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      rd_q       <= '0;
      wr_q       <= '0;
      count_q    <= '0;
      fpc_q      <= '{default: '0};
      finstr_q   <= '{default: '0};
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      count_q    <= count_d;
      fpc_q      <= fpc_d;
      finstr_q   <= finstr_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed scenarios plus randomized run against a behavioural fetch model
module tb_instr_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  logic clk = 0, rst = 1, redirect = 0, halt = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, instr_valid;
  logic [31:0] imem_addr, instr, instr_pc;
  logic [$clog2(DEPTH):0] occupancy;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready), .occupancy(occupancy)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00100093;
      32'h4:   return 32'h00200113;
      32'h8:   return 32'h002081B3;
      32'hC:   return 32'h00100073;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endcase
  endfunction

  always @(posedge clk) imem_rdata <= word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; redirect = 0; halt = 0; instr_ready = 0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; redirect = 0; halt = 0; instr_ready = 1;
    tick(); tick();
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req); else passed++;
    checks++; if (imem_addr !== RESET_PC) $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %0b want 0", instr_valid); else passed++;
    checks++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else passed++;
    checks++; if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h want 0", instr_pc); else passed++;
    checks++; if (occupancy !== '0) $display("FAIL reset_occ: got %0d want 0", occupancy); else passed++;
  endtask

  task automatic test_straight();
    logic [31:0] e;
    do_reset();
    instr_ready = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) begin
        checks++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) $display("FAIL straight_first_req: got %0b/%h want 1/%h", imem_req, imem_addr, RESET_PC); else passed++;
      end
      if (c < 2) begin
        checks++; if (instr_valid !== 1'b0) $display("FAIL straight_early_valid c%0d: got %0b want 0", c, instr_valid); else passed++;
      end else begin
        e = RESET_PC + 32'(4 * (c - 2));
        checks++; if ({instr_valid, instr, instr_pc} !== {1'b1, word(e), e}) $display("FAIL straight_out c%0d: got %0b/%h/%h want 1/%h/%h", c, instr_valid, instr, instr_pc, word(e), e); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e;
    do_reset();
    e = RESET_PC;
    for (int c = 0; c < 22; c++) begin
      if (c == 10) instr_ready = 1;
      @(negedge clk);
      if (c >= 5 && c <= 10) begin
        checks++; if ({occupancy, imem_req} !== {3'd4, 1'b0}) $display("FAIL bp_full c%0d: got occ %0d req %0b want 4/0", c, occupancy, imem_req); else passed++;
      end
      if (c == 11) begin
        checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) $display("FAIL bp_resume: got %0b/%h want 1/00000010", imem_req, imem_addr); else passed++;
      end
      if (instr_valid && instr_ready) begin
        checks++; if ({instr_pc, instr} !== {e, word(e)}) $display("FAIL bp_order: got %h/%h want %h/%h", instr_pc, instr, e, word(e)); else passed++;
        e = e + 32'd4;
      end
      tick();
    end
    checks++; if (e < 32'h14) $display("FAIL bp_count: got next pc %h want >= 00000014", e); else passed++;
  endtask

  task automatic test_redirect_kill();
    int n;
    bit found;
    do_reset();
    tick(); tick(); tick();
    redirect = 1; redirect_pc = 32'h22;
    @(negedge clk);
    checks++; if ({imem_req, occupancy, instr_valid} !== {1'b0, 3'd2, 1'b1}) $display("FAIL rk_redirect_cycle: got req %0b occ %0d valid %0b want 0/2/1", imem_req, occupancy, instr_valid); else passed++;
    tick();
    redirect = 0; instr_ready = 1;
    @(negedge clk);
    checks++; if ({occupancy, imem_req, imem_addr} !== {3'd0, 1'b1, 32'h20}) $display("FAIL rk_next_req: got occ %0d req %0b addr %h want 0/1/00000020", occupancy, imem_req, imem_addr); else passed++;
    n = 0; found = 0;
    while (!found && n < 8) begin
      tick(); n++;
      @(negedge clk);
      if (instr_valid) found = 1;
    end
    checks++; if (!found || n != 2) $display("FAIL rk_latency: got found %0b after %0d want 1 after 2", found, n); else passed++;
    checks++; if ({instr_pc, instr} !== {32'h20, word(32'h20)}) $display("FAIL rk_first: got %h/%h want 00000020/%h", instr_pc, instr, word(32'h20)); else passed++;
  endtask

  task automatic test_halt();
    do_reset();
    instr_ready = 1;
    tick(); tick(); tick(); tick();
    halt = 1;
    for (int c = 4; c < 10; c++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) $display("FAIL halt_req c%0d: got %0b want 0", c, imem_req); else passed++;
      if (c == 5) begin
        checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'hC, 32'h00100073}) $display("FAIL halt_ebreak: got %0b/%h/%h want 1/0000000c/00100073", instr_valid, instr_pc, instr); else passed++;
      end
      if (c == 7) begin
        checks++; if ({occupancy, instr_valid} !== {3'd0, 1'b0}) $display("FAIL halt_drain: got occ %0d valid %0b want 0/0", occupancy, instr_valid); else passed++;
      end
      tick();
    end
    halt = 0;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) $display("FAIL halt_resume: got %0b/%h want 1/00000010", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_wrap();
    do_reset();
    instr_ready = 1;
    tick(); tick();
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    tick();
    redirect = 0;
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) $display("FAIL wrap_req0: got %0b/%h want 1/fffffffc", imem_req, imem_addr); else passed++;
    tick();
    @(negedge clk);
    checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL wrap_req1: got %0b/%h want 1/00000000", imem_req, imem_addr); else passed++;
    tick();
    @(negedge clk);
    checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'hFFFF_FFFC, word(32'hFFFF_FFFC)}) $display("FAIL wrap_out0: got %0b/%h/%h want 1/fffffffc/%h", instr_valid, instr_pc, instr, word(32'hFFFF_FFFC)); else passed++;
    tick();
    @(negedge clk);
    checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h0, word(32'h0)}) $display("FAIL wrap_out1: got %0b/%h/%h want 1/00000000/%h", instr_valid, instr_pc, instr, word(32'h0)); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(); tick(); tick();
    rst = 1;
    @(negedge clk);
    checks++; if (imem_req !== 1'b0) $display("FAIL rmid_req_in_rst: got %0b want 0", imem_req); else passed++;
    tick();
    rst = 0;
    @(negedge clk);
    checks++; if ({instr_valid, instr, instr_pc, occupancy} !== {1'b0, 32'h0, 32'h0, 3'd0}) $display("FAIL rmid_outputs: got %0b/%h/%h/%0d want 0/0/0/0", instr_valid, instr, instr_pc, occupancy); else passed++;
    checks++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) $display("FAIL rmid_restart: got %0b/%h want 1/%h", imem_req, imem_addr, RESET_PC); else passed++;
    instr_ready = 1;
    tick();
    @(negedge clk);
    checks++; if (occupancy !== 3'd0) $display("FAIL rmid_discard: got occ %0d want 0", occupancy); else passed++;
    tick();
    @(negedge clk);
    checks++; if ({instr_valid, instr_pc, instr} !== {1'b1, RESET_PC, word(RESET_PC)}) $display("FAIL rmid_first: got %0b/%h/%h want 1/%h/%h", instr_valid, instr_pc, instr, RESET_PC, word(RESET_PC)); else passed++;
  endtask

  task automatic test_redirect_pop();
    int n;
    bit found;
    do_reset();
    instr_ready = 1;
    tick(); tick(); tick();
    redirect = 1; redirect_pc = 32'h40;
    @(negedge clk);
    checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h4}) $display("FAIL rp_pre: got %0b/%h want 1/00000004", instr_valid, instr_pc); else passed++;
    tick();
    redirect = 0;
    @(negedge clk);
    checks++; if ({occupancy, instr_valid} !== {3'd0, 1'b0}) $display("FAIL rp_flush: got occ %0d valid %0b want 0/0", occupancy, instr_valid); else passed++;
    n = 0; found = 0;
    while (!found && n < 8) begin
      tick(); n++;
      @(negedge clk);
      if (instr_valid) found = 1;
    end
    checks++; if (!found || n != 2) $display("FAIL rp_latency: got found %0b after %0d want 1 after 2", found, n); else passed++;
    checks++; if ({instr_pc, instr} !== {32'h40, word(32'h40)}) $display("FAIL rp_first: got %h/%h want 00000040/%h", instr_pc, instr, word(32'h40)); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] nout, nreq;
    int occ_m;
    bit prev, exp_req, pop_m;
    do_reset();
    nout = RESET_PC; nreq = RESET_PC; occ_m = 0; prev = 0;
    for (int i = 0; i < 600; i++) begin
      instr_ready = $urandom_range(0, 9) < 7;
      if ($urandom_range(0, 19) == 0) halt = !halt;
      redirect = $urandom_range(0, 24) == 0;
      redirect_pc = $urandom;
      @(negedge clk);
      exp_req = !halt && !redirect && (occ_m + int'(prev) < DEPTH);
      pop_m = occ_m > 0 && instr_ready;
      checks++; if ({occupancy, instr_valid} !== {3'(occ_m), occ_m > 0}) $display("FAIL rnd_occ i%0d: got %0d/%0b want %0d/%0b", i, occupancy, instr_valid, occ_m, occ_m > 0); else passed++;
      checks++; if (imem_req !== exp_req) $display("FAIL rnd_req i%0d: got %0b want %0b", i, imem_req, exp_req); else passed++;
      if (exp_req) begin
        checks++; if (imem_addr !== nreq) $display("FAIL rnd_addr i%0d: got %h want %h", i, imem_addr, nreq); else passed++;
        nreq = nreq + 32'd4;
      end
      if (redirect) begin
        nout = redirect_pc & ~32'h3;
        nreq = nout;
        occ_m = 0;
      end else begin
        if (pop_m) begin
          checks++; if ({instr_pc, instr} !== {nout, word(nout)}) $display("FAIL rnd_pop i%0d: got %h/%h want %h/%h", i, instr_pc, instr, nout, word(nout)); else passed++;
          nout = nout + 32'd4;
        end
        occ_m = occ_m + int'(prev) - int'(pop_m);
      end
      prev = exp_req;
      tick();
    end
    halt = 0; redirect = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_kill();
    test_halt();
    test_wrap();
    test_reset_mid();
    test_redirect_pop();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Fetch stage between the synchronous code memory and the CPU decode stage. It owns the fetch PC and issues one word-aligned read per cycle to the code memory, which has a fixed 1-cycle read latency. Returned instructions are buffered with their PC in a small FIFO and presented to decode over a valid/ready handshake. Execute-stage redirects (branch, jump, trap) flush the block; a halt from EBREAK decode stops fetching.

## Interface

- DEPTH, 4: instruction queue entries; power of two, minimum 2
- RESET_PC, 32'h0000_0000: first fetch address after reset

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read request to code memory this cycle
- imem_addr  out  32  byte address of the request, always word-aligned; memory indexes word imem_addr[31:2]
- imem_rdata  in  32  read data; valid the cycle after a request
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored and treated as 0
- halt  in  1  level; while high, no new requests are issued
- instr_valid  out  1  queue head valid
- instr  out  32  head instruction word
- instr_pc  out  32  PC of head instruction
- instr_ready  in  1  decode accepts head when instr_valid && instr_ready
- occupancy  out  $clog2(DEPTH)+1  queued entries, for debug

## Operation

- State: pc (32), inflight (1 bit), response PC (32), kill (1 bit), FIFO of {pc, instr} with count.
- Issue rule: imem_req = !rst && !halt && !redirect && (count + inflight < DEPTH). Pops in the same cycle are not credited. On issue: imem_addr = pc, and pc <= pc + 4, which wraps modulo 2^32.
- Response: the cycle after an issue, {response PC, imem_rdata} is enqueued unless kill is set. Overflow is impossible by the issue rule. The bench flags any overflow as an error.
- Pop: when instr_valid && instr_ready, the head is removed. Push and pop in the same cycle keep count unchanged.
- Redirect has priority over everything:
  - the FIFO is cleared, and a pop in the same cycle is discarded;
  - the in-flight response, if any, is killed;
  - pc <= {redirect_pc[31:2], 2'b00};
  - no request is issued in the redirect cycle.
- Halt: issuing stops. Queued and in-flight entries still drain normally. Deasserting halt resumes from the current pc. Redirect during halt updates pc and flushes, but no fetch occurs until halt drops.
- Reset mid-operation: all state returns to reset values, and any in-flight response is discarded.

## Timing

- Reset values:
  - imem_req 0, imem_addr RESET_PC
  - instr_valid 0, instr 0, instr_pc 0, occupancy 0
  - pc RESET_PC, inflight 0, kill 0
- Cycle 0 = first cycle with rst low: imem_req=1, imem_addr=RESET_PC.
- Cycle 1: data enqueued. Cycle 2: instr_valid=1, instr_pc=RESET_PC.
- Latency from request to instr_valid is 2 cycles. From redirect assertion to the first valid at redirect_pc is 3 cycles (redirect cycle, request, response).
- Throughput: 1 instr/cycle sustained while instr_ready is held high.
- Outputs instr, instr_pc, instr_valid come directly from FIFO registers, with no combinational path from imem_rdata.
- When the queue is full and instr_ready=0, requests stop. Requests resume the cycle after the first pop frees a credit.

## Test plan

- Straight-line fetch:
  - Stimulus: memory words 0..3 = 00100093, 00200113, 002081B3, 00100073; instr_ready=1; no redirect or halt.
  - Required: instr/instr_pc pairs are (00100093,0), (00200113,4), (002081B3,8), (00100073,C) on consecutive cycles starting at cycle 2.
- Backpressure:
  - Stimulus: instr_ready=0 for 10 cycles, then 1.
  - Required: occupancy saturates at 4; imem_req stays 0 while 4 entries are queued; no instruction is lost or duplicated; PCs 0,4,8,C,10 appear in order.
- Redirect with kill:
  - Stimulus: redirect=1 with redirect_pc=0x22 while an entry is in flight and 2 are queued.
  - Required: the next request is at 0x20, issued the cycle after redirect; the first instr_valid carries instr_pc=0x20; no stale PC ever appears at the output.
- Halt:
  - Stimulus: assert halt after word 3 (EBREAK) is requested.
  - Required: imem_req=0 while halt is high; the queue drains to occupancy 0. Deassert halt: fetch resumes at 0x10.
- Wrap and reset:
  - Stimulus: redirect to 0xFFFFFFFC.
  - Required: the next request is at 0x00000000.
  - Stimulus: rst pulsed for 1 cycle with the queue half full.
  - Required: all outputs return to reset values the next cycle, and fetch restarts at RESET_PC.
- Simultaneous redirect and pop:
  - Stimulus: redirect while instr_valid && instr_ready.
  - Required: occupancy=0 next cycle, and the first valid after the redirect carries the redirect_pc instruction.
